fpgasynth_ctrl_bank: RTL and testbench

FPGASYNTH_CTRL_BANK -- requirements
Module: fpgaSynth_ctrl_bank

---
 rtl/fpgasynth_ctrl_bank.sv | 187 ++++++++++++++++++
 tb/tb_fpgasynth_ctrl_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fpgasynth_ctrl_bank.sv
// ---------------------------------------------------------------------------
// fpgasynth_ctrl_bank
//
// Bank of CHANNELS double-buffered control registers behind a small
// memory-mapped slave port. Software writes shadow registers (direct, bit-set
// or bit-clear). The shadows are copied to the live registers either right
// away (immediate mode) or all together on the next sync_tick after a commit
// has been requested (sync mode). Live values drive out_port. Each channel has
// a one-cycle update_strobe that fires when its live value actually changes.
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset
//   address[4:0]   word address: 0..7 shadow, 8..15 set/live,
//                  16..23 clear/live, 24 control
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata[31:0] write data
//   sync_tick      one-cycle commit opportunity (e.g. sample strobe)
//   readdata[31:0] combinational read data, zero-extended
//   out_port       live values, channel i at [i*WIDTH +: WIDTH]
//   update_strobe  per-channel one-cycle change pulse
//   commit_pending commit request outstanding
// ---------------------------------------------------------------------------
module fpgasynth_ctrl_bank #(
    parameter int          WIDTH             = 3,
    parameter int          CHANNELS          = 4,
    parameter logic [31:0] RESET_VAL         = 32'd0,
    parameter bit          IMMEDIATE_DEFAULT = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    input  logic                      sync_tick,
    output logic [31:0]               readdata,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic [CHANNELS-1:0]       update_strobe,
    output logic                      commit_pending
);

    localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];

    logic                      wr_en;
    logic [1:0]                region;
    logic [2:0]                ch;
    logic                      ctrl_wr;
    logic                      sync_commit;
    logic                      commit_all;
    logic                      mode_q, mode_d;
    logic                      pending_q, pending_d;
    logic [WIDTH-1:0]          wd_w;
    logic [CHANNELS*WIDTH-1:0] shadow_flat;
    logic [CHANNELS*WIDTH-1:0] live_flat;
    logic                      unused_wd;

    assign wr_en   = chipselect & ~write_n;
    assign region  = address[4:3];
    assign ch      = address[2:0];
    assign ctrl_wr = wr_en && (address == 5'd24);
    assign wd_w    = writedata[WIDTH-1:0];

    // Only the low WIDTH bits (and two control bits) are meaningful.
    assign unused_wd = ^writedata;

    // A sync commit uses the registered mode and pending, so a pending bit
    // set on this same edge cannot be consumed by this tick.
    assign sync_commit = !mode_q && pending_q && sync_tick;
    assign commit_all  = (ctrl_wr && writedata[1]) || sync_commit;

    // -----------------------------------------------------------------------
    // Mode / pending control
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d    = mode_q;
        pending_d = pending_q;
        if (sync_commit) begin
            pending_d = 1'b0;
        end
        if (ctrl_wr) begin
            if (writedata[1]) begin
                mode_d    = 1'b1;
                pending_d = 1'b0;
            end else begin
                mode_d = 1'b0;
                // A fresh request survives a commit on the same edge.
                if (writedata[0]) begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= IMMEDIATE_DEFAULT;
            pending_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pending_q <= pending_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel shadow / live / strobe
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             hit;
            logic [WIDTH-1:0] shadow_q, shadow_d;
            logic [WIDTH-1:0] live_q, live_d;
            logic             strobe_q, strobe_d;

            // Channels at or above CHANNELS never match, so such writes
            // fall through with no effect.
            assign hit = wr_en && (region != 2'd3) && (ch == 3'(gi));

            always_comb begin
                shadow_d = shadow_q;
                if (hit) begin
                    case (region)
                        2'd0:    shadow_d = wd_w;
                        2'd1:    shadow_d = shadow_q | wd_w;
                        2'd2:    shadow_d = shadow_q & ~wd_w;
                        default: shadow_d = shadow_q;
                    endcase
                end

                // Commits copy the pre-edge shadow; a same-edge shadow write
                // waits for the next commit.
                live_d = live_q;
                if (commit_all) begin
                    live_d = shadow_q;
                end else if (hit && mode_q) begin
                    live_d = shadow_d;
                end

                strobe_d = (live_d != live_q);
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_q <= RST_W;
                    live_q   <= RST_W;
                    strobe_q <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    live_q   <= live_d;
                    strobe_q <= strobe_d;
                end
            end

            assign shadow_flat[gi*WIDTH +: WIDTH] = shadow_q;
            assign live_flat[gi*WIDTH +: WIDTH]   = live_q;
            assign update_strobe[gi]              = strobe_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read mux (combinational, independent of chipselect)
    // -----------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        if (region == 2'd3) begin
            if (ch == 3'd0) begin
                readdata = {30'd0, mode_q, pending_q};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch == 3'(i)) begin
                    if (region == 2'd0) begin
                        readdata = 32'(shadow_flat[i*WIDTH +: WIDTH]);
                    end else begin
                        readdata = 32'(live_flat[i*WIDTH +: WIDTH]);
                    end
                end
            end
        end
    end

    assign out_port       = live_flat;
    assign commit_pending = pending_q;

endmodule

// File: tb/tb_fpgasynth_ctrl_bank.sv
module tb_fpgasynth_ctrl_bank;

    logic        clk;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        sync_tick;
    logic [31:0] readdata;
    logic [11:0] out_port;
    logic [3:0]  update_strobe;
    logic        commit_pending;

    int total = 0;
    int bad   = 0;

    fpgasynth_ctrl_bank #(
        .WIDTH(3), .CHANNELS(4), .RESET_VAL(32'd0), .IMMEDIATE_DEFAULT(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .sync_tick(sync_tick), .readdata(readdata), .out_port(out_port),
        .update_strobe(update_strobe), .commit_pending(commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Write occurs on the posedge between the two negedges; returns at the
    // negedge right after, when strobes from that edge are visible.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        sync_tick = 1'b1;
        @(negedge clk);
        sync_tick = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; sync_tick = 1'b0;
        #12;
        // Reset state
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_pending", 32'(commit_pending), 32'h0);
        check("rst_strobe", 32'(update_strobe), 32'h0);
        read_chk("rst_ctrl", 5'd24, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Sync commit
        bus_write(5'd1, 32'd5);
        bus_write(5'd24, 32'd1);
        check("sync_pend_set", 32'(commit_pending), 32'h1);
        check("sync_no_early", 32'(out_port), 32'h0);
        tick();
        check("sync_out", 32'(out_port[5:3]), 32'd5);
        check("sync_strobe", 32'(update_strobe), 32'h2);
        check("sync_pend_clr", 32'(commit_pending), 32'h0);
        @(negedge clk);
        check("sync_strobe_off", 32'(update_strobe), 32'h0);

        // Same-cycle collision
        bus_write(5'd24, 32'd1);
        @(negedge clk);
        address = 5'd2; writedata = 32'd3; chipselect = 1'b1; write_n = 1'b0;
        sync_tick = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; sync_tick = 1'b0;
        check("coll_live2", 32'(out_port[8:6]), 32'd0);
        check("coll_strobe", 32'(update_strobe), 32'h0);
        check("coll_pend", 32'(commit_pending), 32'h0);
        read_chk("coll_shadow2", 5'd2, 32'd3);
        read_chk("coll_live2_rd", 5'd10, 32'd0);

        // Set / clear
        bus_write(5'd0, 32'd1);
        bus_write(5'd8, 32'd6);
        bus_write(5'd16, 32'd2);
        read_chk("setclr_shadow0", 5'd0, 32'd5);
        bus_write(5'd8, 32'hFFFF_FFF8);
        read_chk("set_high_ignored", 5'd0, 32'd5);
        read_chk("setclr_live0", 5'd8, 32'd0);

        // Boundaries
        bus_write(5'd5, 32'd7);
        bus_write(5'd30, 32'd7);
        read_chk("bnd_rd5", 5'd5, 32'd0);
        read_chk("bnd_rd30", 5'd30, 32'd0);
        read_chk("bnd_rd13", 5'd13, 32'd0);
        check("bnd_out", 32'(out_port), 32'h028);
        bus_write(5'd24, 32'd1);
        bus_write(5'd24, 32'd1);
        check("dbl_pend", 32'(commit_pending), 32'h1);
        tick();
        check("dbl_out", 32'(out_port), 32'h0ED);
        check("dbl_strobe", 32'(update_strobe), 32'h5);
        check("dbl_pend_clr", 32'(commit_pending), 32'h0);
        tick();
        check("dbl_no_second", 32'(out_port), 32'h0ED);
        check("dbl_strobe_off", 32'(update_strobe), 32'h0);

        // Immediate mode
        bus_write(5'd24, 32'd2);
        read_chk("imm_ctrl", 5'd24, 32'h2);
        check("imm_enter_strobe", 32'(update_strobe), 32'h0);
        bus_write(5'd3, 32'd7);
        check("imm_out3", 32'(out_port[11:9]), 32'd7);
        check("imm_strobe3", 32'(update_strobe), 32'h8);
        @(negedge clk);
        check("imm_strobe3_off", 32'(update_strobe), 32'h0);
        bus_write(5'd3, 32'd7);
        check("imm_rewrite", 32'(update_strobe), 32'h0);
        bus_write(5'd8, 32'd2);
        check("imm_set_out0", 32'(out_port[2:0]), 32'd7);
        check("imm_set_strobe", 32'(update_strobe), 32'h1);

        // Mid-operation reset
        bus_write(5'd24, 32'd1);
        check("mid_pend", 32'(commit_pending), 32'h1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_out", 32'(out_port), 32'h0);
        check("mid_pend_clr", 32'(commit_pending), 32'h0);
        check("mid_strobe", 32'(update_strobe), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rel_strobe", 32'(update_strobe), 32'h0);
        tick();
        check("rel_out", 32'(out_port), 32'h0);
        check("rel_tick_strobe", 32'(update_strobe), 32'h0);
        check("rel_pend", 32'(commit_pending), 32'h0);
        read_chk("rel_ctrl", 5'd24, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
